stream_demux: RTL and testbench
===============================

# stream_demux

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking and packet-locked channel selection. Successor to the combinational 1-to-8 demux: each packet on a single input stream is steered to one of N_OUT output streams, chosen by address or by round-robin. Sits between a packet source and N_OUT independent consumers in the datapath.

## Interface
- WIDTH, 8, data bits per beat
- N_OUT, 8, number of output channels (2..256)
- SEL_W, $clog2(N_OUT), select width (derived; do not override)
- RR_MODE, 0, 0 = addressed (s_sel chooses channel), 1 = round-robin (s_sel ignored)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_data  in  WIDTH  input beat data
- s_sel  in  SEL_W  destination channel, sampled on first beat of a packet only
- s_last  in  1  final beat of packet
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- m_data  out  N_OUT*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- m_last  out  N_OUT  per-channel last flag
- m_valid  out  N_OUT  per-channel valid; at most one bit set
- m_ready  in  N_OUT  per-channel ready
- err_sel  out  1  one-cycle pulse: packet start with s_sel >= N_OUT

## Operation
- FSM states: IDLE (no packet open), BUSY (locked to channel cur), DROP (discarding illegal-select packet).
- IDLE, accepted beat: addressed mode latches cur = s_sel; RR_MODE latches cur = rr_ptr. If s_last also set, packet is single-beat and FSM stays IDLE; else -> BUSY.
- IDLE, addressed mode, s_sel >= N_OUT: beat discarded, err_sel pulses; s_last ? stay IDLE : -> DROP.
- BUSY: beats go to cur regardless of s_sel; accepted beat with s_last -> IDLE.
- DROP: s_ready = 1, beats discarded, no m_valid; accepted s_last -> IDLE. err_sel pulses only on the first beat.
- One output register (slot) shared by all channels: holds data, last, channel index, valid.
- s_ready = ~slot_valid | m_ready[slot_ch] (in DROP, forced 1). Combinational path m_ready -> s_ready allowed.
- m_valid[k] = slot_valid & (slot_ch == k); m_data/m_last replicate slot contents on every channel, qualified only by m_valid.
- rr_ptr advances by 1 when the last beat of a packet is accepted (RR_MODE=1); wraps N_OUT-1 -> 0. Unused when RR_MODE=0.
- Data beats are never reordered, duplicated or dropped except in DROP/illegal-start cases.

## Timing
- Reset (async assert, sync-release assumed upstream): m_valid = 0, m_data = 0, m_last = 0, err_sel = 0, FSM = IDLE, cur = 0, rr_ptr = 0; s_ready = 1 immediately after reset.
- Latency: beat accepted at edge n appears on m_valid/m_data after edge n (visible cycle n+1).
- Throughput: 1 beat/cycle while destination m_ready held high.
- Backpressure: slot holds data, last and channel stable while m_valid & ~m_ready; s_ready low.
- Simultaneous drain and fill: slot reloads in same cycle, no bubble.
- Last beat of packet A and first beat of packet B to a different channel: B may enter slot the cycle after A drains from it; no extra idle cycle required.
- m_ready on non-selected channels is ignored.
- Reset mid-packet: open packet abandoned, slot contents lost, rr_ptr returns to 0.

## Structure
- Package stream_demux_pkg: FSM state enum (ST_IDLE, ST_BUSY, ST_DROP), RR_MODE constants (MODE_ADDR = 0, MODE_RR = 1).
- Sub-module stream_demux_slot: single-entry register (data, last, ch, valid) with load/drain handshake; parametrised on WIDTH and SEL_W.
- Top holds FSM, rr_ptr, select latch, per-channel valid decode and err_sel.

## Test plan
- N_OUT=8, addressed: 3-beat packet, s_sel=5, data 0xA1,0xA2,0xA3 -> m_valid[5] only, same data one cycle later, m_last[5] on 0xA3; s_sel changed to 2 mid-packet has no effect.
- Backpressure: m_ready[3]=0 for 4 cycles during packet to channel 3 -> s_ready low, m_data held at same beat, no loss after release.
- Illegal select: N_OUT=6, s_sel=7, 2-beat packet -> err_sel one pulse, no m_valid; next packet s_sel=0 delivered normally.
- RR_MODE=1, N_OUT=4: five single-beat packets -> channels 0,1,2,3,0 in order.
- Back-to-back single-beat packets to channels 1 then 6 with all m_ready=1 -> one beat per cycle, m_valid[1] then m_valid[6] on consecutive cycles.
- rst_n asserted mid-packet with slot full -> m_valid = 0 asynchronously; after release, new packet to channel 0 delivers correctly.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types and constants for the stream_demux block.
//   state_t      : packet FSM state (IDLE / BUSY / DROP)
//   MODE_ADDR/RR : values for the RR_MODE parameter
//   wrap_inc     : modulo-n increment used by the round-robin pointer
package stream_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no packet open
    ST_BUSY = 2'd1,  // locked to the latched channel
    ST_DROP = 2'd2   // discarding a packet that started with an illegal select
  } state_t;

  localparam int unsigned MODE_ADDR = 0;
  localparam int unsigned MODE_RR   = 1;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// stream_demux_if: bundles the input stream, the N_OUT output streams and the
// illegal-select error pulse of stream_demux.
//   master : packet source / consumers side (drives s_*, m_ready)
//   slave  : the demultiplexer (drives s_ready, m_*, err_sel)
interface stream_demux_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 8,
  parameter int unsigned SEL_W = $clog2(N_OUT)
);
  logic [WIDTH-1:0]       s_data;
  logic [SEL_W-1:0]       s_sel;
  logic                   s_last;
  logic                   s_valid;
  logic                   s_ready;
  logic [N_OUT*WIDTH-1:0] m_data;
  logic [N_OUT-1:0]       m_last;
  logic [N_OUT-1:0]       m_valid;
  logic [N_OUT-1:0]       m_ready;
  logic                   err_sel;

  modport master (
    output s_data, s_sel, s_last, s_valid, m_ready,
    input  s_ready, m_data, m_last, m_valid, err_sel
  );

  modport slave (
    input  s_data, s_sel, s_last, s_valid, m_ready,
    output s_ready, m_data, m_last, m_valid, err_sel
  );
endinterface

// File: rtl/stream_demux_slot.sv
// stream_demux_slot: single-entry output register shared by all channels.
//   in_valid/in_ready  : load handshake (in_ready = empty or draining this cycle)
//   in_data/last/ch    : beat to store and its destination channel
//   out_ready          : ready of the channel currently held (out_ch)
//   out_valid/data/last/ch : stored beat; held stable while out_ready is low
module stream_demux_slot #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [SEL_W-1:0] in_ch,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [SEL_W-1:0] out_ch
);

  // Drain and refill may happen on the same edge, giving full throughput.
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
      out_ch    <= in_ch;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N_OUT stream demultiplexer with packet-locked
// channel selection (addressed via s_sel, or round-robin when RR_MODE=1).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream_demux_if slave modport
//                s_data/s_sel/s_last/s_valid/s_ready : input stream
//                m_data/m_last/m_valid/m_ready       : N_OUT output streams
//                err_sel : one-cycle pulse when a packet starts with s_sel >= N_OUT
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned N_OUT   = 8,
  parameter int unsigned SEL_W   = $clog2(N_OUT),
  parameter int unsigned RR_MODE = MODE_ADDR
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_demux_if.slave  bus
);

  state_t           state;
  logic [SEL_W-1:0] cur;
  logic [SEL_W-1:0] rr_ptr;
  logic             err_q;

  logic             slot_in_ready;
  logic             slot_valid;
  logic [WIDTH-1:0] slot_data;
  logic             slot_last;
  logic [SEL_W-1:0] slot_ch;

  logic             accept;
  logic             illegal;
  logic             load;
  logic [SEL_W-1:0] start_ch;
  logic [SEL_W-1:0] load_ch;

  // Channel a new packet would lock to if it started this cycle.
  assign start_ch = (RR_MODE == MODE_RR) ? rr_ptr : bus.s_sel;
  assign illegal  = (RR_MODE == MODE_ADDR) && (32'(bus.s_sel) >= N_OUT);

  // DROP swallows beats without touching the slot, so it never backpressures.
  assign bus.s_ready = (state == ST_DROP) | slot_in_ready;
  assign accept      = bus.s_valid & bus.s_ready;
  assign load        = accept & ((state == ST_BUSY) | ((state == ST_IDLE) & ~illegal));
  assign load_ch     = (state == ST_BUSY) ? cur : start_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cur    <= '0;
      rr_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        unique case (state)
          ST_IDLE: begin
            if (illegal) begin
              err_q <= 1'b1;
              if (!bus.s_last) state <= ST_DROP;
            end else begin
              cur <= start_ch;
              if (!bus.s_last) state <= ST_BUSY;
            end
          end
          ST_BUSY: if (bus.s_last) state <= ST_IDLE;
          ST_DROP: if (bus.s_last) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
        // Packet end advances the round-robin pointer (DROP never occurs in RR mode).
        if (RR_MODE == MODE_RR && bus.s_last && state != ST_DROP)
          rr_ptr <= SEL_W'(wrap_inc(32'(rr_ptr), N_OUT));
      end
    end
  end

  stream_demux_slot #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (load),
    .in_data   (bus.s_data),
    .in_last   (bus.s_last),
    .in_ch     (load_ch),
    .in_ready  (slot_in_ready),
    .out_ready (bus.m_ready[slot_ch]),
    .out_valid (slot_valid),
    .out_data  (slot_data),
    .out_last  (slot_last),
    .out_ch    (slot_ch)
  );

  // Data/last are replicated on every channel; only m_valid selects.
  always_comb begin
    bus.m_valid = '0;
    for (int unsigned k = 0; k < N_OUT; k++)
      bus.m_valid[k] = slot_valid && (32'(slot_ch) == k);
  end

  assign bus.m_data  = {N_OUT{slot_data}};
  assign bus.m_last  = {N_OUT{slot_last}};
  assign bus.err_sel = err_q;

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;
  import stream_demux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_demux_if #(.WIDTH(8), .N_OUT(8)) if8 ();
  stream_demux_if #(.WIDTH(8), .N_OUT(6)) if6 ();
  stream_demux_if #(.WIDTH(8), .N_OUT(4)) if4 ();

  stream_demux #(.WIDTH(8), .N_OUT(8), .RR_MODE(MODE_ADDR)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  stream_demux #(.WIDTH(8), .N_OUT(6), .RR_MODE(MODE_ADDR)) u6 (.clk(clk), .rst_n(rst_n), .bus(if6));
  stream_demux #(.WIDTH(8), .N_OUT(4), .RR_MODE(MODE_RR))   u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet-level model: every accepted beat is routed by the packet rules into
  // an ordered list of expected deliveries per design instance.
  typedef struct {
    int unsigned dut;
    int unsigned ch;
    logic [7:0]  data;
    logic        last;
  } beat_t;

  beat_t       expq[$];
  int unsigned m_state[3];  // 0 no packet, 1 open, 2 discarding
  int unsigned m_cur[3];
  int unsigned m_rr[3];
  logic        exp_err[3];

  task automatic model_beat(input int unsigned d, input int unsigned n, input bit rr,
                            input logic acc, input logic [7:0] data,
                            input int unsigned sel, input logic last);
    beat_t b;
    exp_err[d] = 1'b0;
    if (!acc) return;
    if (m_state[d] == 2) begin
      if (last) m_state[d] = 0;
      return;
    end
    if (m_state[d] == 0) begin
      if (!rr && sel >= n) begin
        exp_err[d] = 1'b1;
        m_state[d] = last ? 0 : 2;
        return;
      end
      m_cur[d]   = rr ? m_rr[d] : sel;
      m_state[d] = 1;
    end
    b.dut = d; b.ch = m_cur[d]; b.data = data; b.last = last;
    expq.push_back(b);
    if (last) begin
      m_state[d] = 0;
      if (rr) m_rr[d] = (m_rr[d] + 1) % n;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      expq.delete();
      for (int d = 0; d < 3; d++) begin
        m_state[d] = 0; m_cur[d] = 0; m_rr[d] = 0; exp_err[d] = 1'b0;
      end
    end else begin
      model_beat(0, 8, 1'b0, if8.s_valid & if8.s_ready, if8.s_data, 32'(if8.s_sel), if8.s_last);
      model_beat(1, 6, 1'b0, if6.s_valid & if6.s_ready, if6.s_data, 32'(if6.s_sel), if6.s_last);
      model_beat(2, 4, 1'b1, if4.s_valid & if4.s_ready, if4.s_data, 32'(if4.s_sel), if4.s_last);
    end
  end

  task automatic cmp_out(input int unsigned d, input logic [7:0] v, input logic [7:0] r,
                         input logic [63:0] data, input logic [7:0] last, input logic err);
    int ch;
    int idx;
    chk($sformatf("err_sel[%0d]", d), 64'(err), 64'(exp_err[d]));
    if (v == 8'h00) return;
    chk($sformatf("onehot[%0d]", d), 64'($countones(v)), 64'd1);
    ch = 0;
    for (int k = 0; k < 8; k++) if (v[k]) ch = k;
    idx = -1;
    for (int i = 0; i < expq.size(); i++) begin
      if (expq[i].dut == d) begin idx = i; break; end
    end
    vectors++;
    if (idx < 0) begin
      miscompares++;
      $display("FAIL unexpected_beat[%0d]: got beat on channel %0d expected none", d, ch);
      return;
    end
    chk($sformatf("channel[%0d]", d), 64'(ch), 64'(expq[idx].ch));
    chk($sformatf("data[%0d]", d), 64'(data[ch*8 +: 8]), 64'(expq[idx].data));
    chk($sformatf("last[%0d]", d), 64'(last[ch]), 64'(expq[idx].last));
    if (r[ch]) expq.delete(idx);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      cmp_out(0, 8'(if8.m_valid), 8'(if8.m_ready), 64'(if8.m_data), 8'(if8.m_last), if8.err_sel);
      cmp_out(1, 8'(if6.m_valid), 8'(if6.m_ready), 64'(if6.m_data), 8'(if6.m_last), if6.err_sel);
      cmp_out(2, 8'(if4.m_valid), 8'(if4.m_ready), 64'(if4.m_data), 8'(if4.m_last), if4.err_sel);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    if8.s_valid = 0; if8.s_data = '0; if8.s_sel = '0; if8.s_last = 0; if8.m_ready = '1;
    if6.s_valid = 0; if6.s_data = '0; if6.s_sel = '0; if6.s_last = 0; if6.m_ready = '1;
    if4.s_valid = 0; if4.s_data = '0; if4.s_sel = '0; if4.s_last = 0; if4.m_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(if8.m_valid), 64'h0);
    chk("rst_m_data",  if8.m_data, 64'h0);
    chk("rst_m_last",  64'(if8.m_last), 64'h0);
    chk("rst_err_sel", 64'(if6.err_sel), 64'h0);
    chk("rst_s_ready", 64'(if8.s_ready), 64'h1);
    rst_n = 1'b1;
    step();

    // Addressed 3-beat packet to channel 5; s_sel changes mid-packet.
    if8.s_valid = 1; if8.s_sel = 3'd5; if8.s_data = 8'hA1; if8.s_last = 0;
    step();
    chk("t1_valid0", 64'(if8.m_valid), 64'h20);
    chk("t1_data0",  64'(if8.m_data[47:40]), 64'hA1);
    if8.s_sel = 3'd2; if8.s_data = 8'hA2;
    step();
    chk("t1_valid1", 64'(if8.m_valid), 64'h20);
    chk("t1_data1",  64'(if8.m_data[47:40]), 64'hA2);
    chk("t1_last1",  64'(if8.m_last[5]), 64'h0);
    if8.s_data = 8'hA3; if8.s_last = 1;
    step();
    chk("t1_valid2", 64'(if8.m_valid), 64'h20);
    chk("t1_data2",  64'(if8.m_data[47:40]), 64'hA3);
    chk("t1_last2",  64'(if8.m_last[5]), 64'h1);
    if8.s_valid = 0; if8.s_last = 0;
    step();
    chk("t1_idle", 64'(if8.m_valid), 64'h0);

    // Backpressure on channel 3 for four cycles; other channels stay ready.
    if8.m_ready = 8'hF7;
    if8.s_valid = 1; if8.s_sel = 3'd3; if8.s_data = 8'hB1; if8.s_last = 0;
    chk("t2_ready_empty", 64'(if8.s_ready), 64'h1);
    step();
    if8.s_data = 8'hB2;
    for (int i = 0; i < 4; i++) begin
      chk("t2_s_ready_low", 64'(if8.s_ready), 64'h0);
      chk("t2_held_valid", 64'(if8.m_valid), 64'h08);
      chk("t2_held_data",  64'(if8.m_data[31:24]), 64'hB1);
      step();
    end
    if8.m_ready = 8'hFF;
    #1;
    chk("t2_release_ready", 64'(if8.s_ready), 64'h1);
    step();
    chk("t2_data_b2", 64'(if8.m_data[31:24]), 64'hB2);
    if8.s_data = 8'hB3; if8.s_last = 1;
    step();
    chk("t2_data_b3", 64'(if8.m_data[31:24]), 64'hB3);
    chk("t2_last_b3", 64'(if8.m_last[3]), 64'h1);
    if8.s_valid = 0; if8.s_last = 0;
    step();

    // Illegal select on the 6-channel instance, then a legal packet.
    if6.s_valid = 1; if6.s_sel = 3'd7; if6.s_data = 8'hC1; if6.s_last = 0;
    step();
    chk("t3_err_pulse", 64'(if6.err_sel), 64'h1);
    chk("t3_no_valid0", 64'(if6.m_valid), 64'h0);
    if6.s_data = 8'hC2; if6.s_last = 1;
    chk("t3_drop_ready", 64'(if6.s_ready), 64'h1);
    step();
    chk("t3_err_once",  64'(if6.err_sel), 64'h0);
    chk("t3_no_valid1", 64'(if6.m_valid), 64'h0);
    if6.s_sel = 3'd0; if6.s_data = 8'hD1; if6.s_last = 1;
    step();
    chk("t3_legal_valid", 64'(if6.m_valid), 64'h01);
    chk("t3_legal_data",  64'(if6.m_data[7:0]), 64'hD1);
    if6.s_valid = 0; if6.s_last = 0;
    step();

    // Round-robin: five single-beat packets land on 0,1,2,3,0.
    if4.s_valid = 1; if4.s_last = 1;
    for (int k = 0; k < 5; k++) begin
      if4.s_data = 8'hE0 + 8'(k);
      if4.s_sel  = 2'(3 - (k % 4));
      step();
      chk($sformatf("t4_rr_ch%0d", k), 64'(if4.m_valid), 64'h1 << (k % 4));
      chk($sformatf("t4_rr_data%0d", k), 64'(if4.m_data[(k % 4)*8 +: 8]), 64'(8'hE0 + 8'(k)));
    end
    if4.s_valid = 0; if4.s_last = 0;
    step();

    // Back-to-back single-beat packets to channels 1 then 6.
    if8.s_valid = 1; if8.s_last = 1; if8.s_sel = 3'd1; if8.s_data = 8'hF1;
    step();
    chk("t5_valid_ch1", 64'(if8.m_valid), 64'h02);
    chk("t5_data_ch1",  64'(if8.m_data[15:8]), 64'hF1);
    chk("t5_ready",     64'(if8.s_ready), 64'h1);
    if8.s_sel = 3'd6; if8.s_data = 8'hF2;
    step();
    chk("t5_valid_ch6", 64'(if8.m_valid), 64'h40);
    chk("t5_data_ch6",  64'(if8.m_data[55:48]), 64'hF2);
    if8.s_valid = 0; if8.s_last = 0;
    step();

    // Reset while the slot holds a stalled beat.
    if8.m_ready = 8'hFB;
    if8.s_valid = 1; if8.s_sel = 3'd2; if8.s_data = 8'h77; if8.s_last = 0;
    step();
    chk("t6_slot_full", 64'(if8.m_valid), 64'h04);
    if8.s_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(if8.m_valid), 64'h0);
    chk("t6_async_data",  if8.m_data, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    if8.m_ready = '1;
    rst_n = 1'b1;
    if8.s_valid = 1; if8.s_sel = 3'd0; if8.s_data = 8'h5A; if8.s_last = 1;
    if4.s_valid = 1; if4.s_sel = 2'd3; if4.s_data = 8'h3C; if4.s_last = 1;
    step();
    chk("t6_post_valid", 64'(if8.m_valid), 64'h01);
    chk("t6_post_data",  64'(if8.m_data[7:0]), 64'h5A);
    chk("t6_rr_restart", 64'(if4.m_valid), 64'h1);
    chk("t6_rr_data",    64'(if4.m_data[7:0]), 64'h3C);
    if8.s_valid = 0; if8.s_last = 0;
    if4.s_valid = 0; if4.s_last = 0;
    repeat (3) step();
    chk("queue_drained", 64'(expq.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
